// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the LEGv8 register file.
//   DATA_WIDTH  - width of every register and data port (64)
//   NUM_REGS    - number of architectural registers (32)
//   ZERO_REG    - index hardwired to read zero and ignore writes (X31/XZR)
//   REG_ADDR_W  - register index width (5)
//   reg_addr_t  - register index type
//   reg_data_t  - register data type
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decode / write-back bus of the register file.
//   master modport: driven by decode and write-back (register numbers,
//                   write data, write enable); receives read data.
//   slave  modport: the register file itself.
// Signals:
//   read_reg1, read_reg2 - read indices (combinational read, 0 latency)
//   write_reg, write_data, reg_write - synchronous write port
//   read_data1, read_data2 - read results
// There is no handshake: a write is accepted on every posedge where
// reg_write=1; reads are pure combinational lookups with no valid/ready.
interface reg_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
);

  reg_addr_t             read_reg1;
  reg_addr_t             read_reg2;
  reg_addr_t             write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );

endinterface

// File: rtl/reg_file_en_reg.sv
// en_reg: DATA_WIDTH-wide register with synchronous active-high reset
// and a write enable. With en_i=0 the stored value recirculates.
// Ports:
//   clk    - clock, updates on posedge
//   reset  - synchronous, active-high; clears the register (beats en_i)
//   en_i   - load enable
//   d_i    - data to load
//   q_o    - stored value
module en_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Recirculating mux in front of each flop.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: LEGv8 register file, NUM_REGS x DATA_WIDTH, two asynchronous
// read ports and one synchronous write port. Index ZERO_REG (XZR) has no
// storage, always reads zero and swallows writes.
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - synchronous, active-high; clears every register, and wins
//            over a write presented in the same cycle
//   bus    - reg_file_if.slave: read_reg1/2, write_reg, write_data,
//            reg_write in; read_data1/2 out
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read of the register being
//   written this cycle returns write_data (write-through forwarding).
//   When undefined, reads see only the stored value (old data).
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);

  localparam reg_addr_t ZERO_IDX = reg_addr_t'(ZERO_REG);

  logic [NUM_REGS-1:0]   wr_en;
  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];

  // One-hot write decode; XZR never gets an enable.
  always_comb begin
    wr_en = '0;
    if (bus.reg_write && (bus.write_reg != ZERO_IDX)) begin
      wr_en[bus.write_reg] = 1'b1;
    end
  end

  // Storage: one en_reg per register except XZR, which is a constant 0.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    if (i == ZERO_REG) begin : g_zero
      assign rf_q[i] = '0;
    end else begin : g_store
      en_reg #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (wr_en[i]),
        .d_i   (bus.write_data),
        .q_o   (rf_q[i])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A write only lands when reset is low, so forwarding obeys the same rule.
  logic wr_fire;
  assign wr_fire = bus.reg_write && !reset && (bus.write_reg != ZERO_IDX);
`endif

  // Read muxes. The XZR check comes last so it overrides any forwarding.
  always_comb begin
    bus.read_data1 = rf_q[bus.read_reg1];
    bus.read_data2 = rf_q[bus.read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (bus.read_reg1 == bus.write_reg)) begin
      bus.read_data1 = bus.write_data;
    end
    if (wr_fire && (bus.read_reg2 == bus.write_reg)) begin
      bus.read_data2 = bus.write_data;
    end
`endif
    if (bus.read_reg1 == ZERO_IDX) begin
      bus.read_data1 = '0;
    end
    if (bus.read_reg2 == ZERO_IDX) begin
      bus.read_data2 = '0;
    end
  end

endmodule
